// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcodes, FSM states and ALU control bundle for alu_exec_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_SLT  = 4'b0111;
    localparam logic [3:0] c_OP_NOR  = 4'b1100;
    localparam logic [3:0] c_OP_SLTU = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        LESS = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic       cin;
        logic [1:0] operation;
    } alu_ctrl_t;

    function automatic alu_ctrl_t mk_ctrl(input logic a_inv, input logic b_inv,
                                          input logic cin, input logic [1:0] operation);
        alu_ctrl_t c;
        c.a_inv     = a_inv;
        c.b_inv     = b_inv;
        c.cin       = cin;
        c.operation = operation;
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core32.sv
// ============================================================================
// Module   : alu_core32
// Brief    : 32-bit ALU core (AND/OR/add/less) with A/B invert and carry-in.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core32
    import alu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_ctrl_t   i_ctrl,
    input  logic        i_less,
    output logic [31:0] o_result,
    output logic        o_cout,
    output logic        o_v,
    output logic        o_sign
);

    logic [31:0] w_aa;
    logic [31:0] w_bb;
    logic [32:0] w_sum;

    assign w_aa  = i_ctrl.a_inv ? ~i_a : i_a;
    assign w_bb  = i_ctrl.b_inv ? ~i_b : i_b;
    assign w_sum = {1'b0, w_aa} + {1'b0, w_bb} + {32'd0, i_ctrl.cin};

    assign o_cout = w_sum[32];
    assign o_v    = (w_aa[31] == w_bb[31]) & (w_sum[31] != w_aa[31]);
    // Sign of the true difference, valid even when the subtraction overflows
    assign o_sign = w_sum[31] ^ o_v;

    always_comb begin
        o_result = '0;
        case (i_ctrl.operation)
            2'b00:   o_result = w_aa & w_bb;
            2'b01:   o_result = w_aa | w_bb;
            2'b10:   o_result = w_sum[31:0];
            default: o_result = {31'd0, i_less};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
// ============================================================================
// Module   : alu_ctrl_dec
// Brief    : Opcode to ALU-core control decode; SLTU enabled by
//            ALU_EXEC_SEQ_SLTU_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic       i_pass2,
    output alu_ctrl_t  o_ctrl,
    output logic       o_is_less,
    output logic       o_is_unsigned,
    output logic       o_is_arith,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl        = mk_ctrl(1'b0, 1'b0, 1'b0, 2'b00);
        o_is_less     = 1'b0;
        o_is_unsigned = 1'b0;
        o_is_arith    = 1'b0;
        o_illegal     = 1'b0;
        case (i_op)
            c_OP_AND: o_ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 2'b00);
            c_OP_OR:  o_ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 2'b01);
            c_OP_ADD: begin
                o_ctrl     = mk_ctrl(1'b0, 1'b0, 1'b0, 2'b10);
                o_is_arith = 1'b1;
            end
            c_OP_SUB: begin
                o_ctrl     = mk_ctrl(1'b0, 1'b1, 1'b1, 2'b10);
                o_is_arith = 1'b1;
            end
            c_OP_SLT: begin
                o_ctrl    = mk_ctrl(1'b0, 1'b1, 1'b1, i_pass2 ? 2'b11 : 2'b10);
                o_is_less = 1'b1;
            end
            c_OP_NOR: o_ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 2'b00);
`ifdef ALU_EXEC_SEQ_SLTU_EN
            c_OP_SLTU: begin
                o_ctrl        = mk_ctrl(1'b0, 1'b1, 1'b1, i_pass2 ? 2'b11 : 2'b10);
                o_is_less     = 1'b1;
                o_is_unsigned = 1'b1;
            end
`endif
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_exec_seq.sv
// ============================================================================
// Module   : alu_exec_seq
// Brief    : Sequenced single-request ALU executor with valid/ready handshake.
//            Optional SLTU opcode via macro ALU_EXEC_SEQ_SLTU_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_seq
    import alu_pkg::*;
#(
    parameter bit ERR_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_ovf,
    output logic        out_cout,
    output logic        out_err
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_less;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_ovf;
    logic        r_cout;
    logic        r_err;

    alu_ctrl_t   w_ctrl;
    logic        w_is_less;
    logic        w_is_unsigned;
    logic        w_is_arith;
    logic        w_illegal;
    logic [31:0] w_core_result;
    logic        w_core_cout;
    logic        w_core_v;
    logic        w_core_sign;
    logic        w_accept;
    logic        w_load_less;
    logic        w_load_out;
    logic [31:0] w_res_nxt;

    alu_ctrl_dec u_dec (
        .i_op          (r_op),
        .i_pass2       (r_state == LESS),
        .o_ctrl        (w_ctrl),
        .o_is_less     (w_is_less),
        .o_is_unsigned (w_is_unsigned),
        .o_is_arith    (w_is_arith),
        .o_illegal     (w_illegal)
    );

    // less is always fed from the flag captured during the EXEC pass
    alu_core32 u_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_ctrl   (w_ctrl),
        .i_less   (r_less),
        .o_result (w_core_result),
        .o_cout   (w_core_cout),
        .o_v      (w_core_v),
        .o_sign   (w_core_sign)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load_less = 1'b0;
        w_load_out  = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (w_is_less) begin
                    w_load_less = 1'b1;
                    w_state_nxt = LESS;
                end else begin
                    w_load_out  = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            LESS: begin
                w_load_out  = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_res_nxt = w_illegal ? 32'd0 : w_core_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= 4'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_less   <= 1'b0;
            r_result <= 32'd0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cout   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op <= in_op;
                r_a  <= in_a;
                r_b  <= in_b;
            end
            if (w_load_less) begin
                r_less <= w_is_unsigned ? ~w_core_cout : w_core_sign;
            end
            if (w_load_out) begin
                r_result <= w_res_nxt;
                r_zero   <= (w_res_nxt == 32'd0);
                r_ovf    <= w_is_arith & w_core_v;
                r_cout   <= w_is_arith & w_core_cout;
                r_err    <= w_illegal & ERR_ON_ILLEGAL;
            end
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == RESP);
    assign out_result = r_result;
    assign out_zero   = r_zero;
    assign out_ovf    = r_ovf;
    assign out_cout   = r_cout;
    assign out_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_seq.sv
// ============================================================================
// Module   : tb_alu_exec_seq
// Brief    : Self-checking bench for alu_exec_seq (directed + random ops);
//            honours ALU_EXEC_SEQ_SLTU_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_seq;

`ifdef ALU_EXEC_SEQ_SLTU_EN
    localparam bit c_SLTU_EN = 1'b1;
`else
    localparam bit c_SLTU_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ovf;
    logic        out_cout;
    logic        out_err;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [3:0]  legal_ops [7] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'hF};

    alu_exec_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
        .out_cout   (out_cout),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Returns {err, cout, ovf, zero, result[31:0]} from plain arithmetic.
    function automatic logic [35:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic [32:0] u;
        logic        v;
        logic        c;
        logic        e;
        longint      s;
        r = 32'd0; v = 1'b0; c = 1'b0; e = 1'b0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin
                u = {1'b0, a} + {1'b0, b};
                r = u[31:0];
                c = u[32];
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s != longint'(int'(s)));
            end
            4'h6: begin
                r = a - b;
                c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s != longint'(int'(s)));
            end
            4'h7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hC: r = ~(a | b);
            4'hF: begin
                if (c_SLTU_EN) r = (a < b) ? 32'd1 : 32'd0;
                else           e = 1'b1;
            end
            default: e = 1'b1;
        endcase
        return {e, c, v, (r == 32'd0), r};
    endfunction

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [35:0] e;
        int          lat;
        int          exp_lat;
        e       = ref_model(op, a, b);
        exp_lat = (op == 4'h7 || (c_SLTU_EN && op == 4'hF)) ? 3 : 2;
        @(negedge clk);
        check({name, "/in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(negedge clk);
        // Scramble the bus so the DUT must have latched the request
        in_valid = 1'b0; in_op = 4'($urandom); in_a = $urandom; in_b = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 8) begin
            check({name, "/in_ready_busy"}, {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        check({name, "/latency"}, lat, exp_lat);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            check({name, "/result"}, out_result, e[31:0]);
            check({name, "/zero"},   {31'd0, out_zero}, {31'd0, e[32]});
            check({name, "/ovf"},    {31'd0, out_ovf},  {31'd0, e[33]});
            check({name, "/cout"},   {31'd0, out_cout}, {31'd0, e[34]});
            check({name, "/err"},    {31'd0, out_err},  {31'd0, e[35]});
            check({name, "/valid_held"}, {31'd0, out_valid}, 32'd1);
            check({name, "/in_ready_resp"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "/valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({name, "/in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rand_operand();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] op;
        int         k;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 4'd0; in_a = 32'd0; in_b = 32'd0;
        repeat (3) @(negedge clk);
        check("rst/in_ready",  {31'd0, in_ready},  32'd1);
        check("rst/out_valid", {31'd0, out_valid}, 32'd0);
        check("rst/result",    out_result, 32'd0);
        check("rst/flags", {27'd0, out_zero, out_ovf, out_cout, out_err}, 32'd0);
        rst = 1'b0;

        run_op("add_ovf",  4'h2, 32'h7FFF_FFFF, 32'h1, 0);
        run_op("sub_zero", 4'h6, 32'd5, 32'd5, 1);
        run_op("slt_neg",  4'h7, 32'h8000_0000, 32'h1, 0);
        run_op("slt_ovf",  4'h7, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2);
        run_op("nor_hold", 4'hC, 32'h0, 32'h0, 4);

        // Reset while in LESS: the pending SLT must vanish
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'h7; in_a = 32'h8000_0000; in_b = 32'h1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_less/in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_less/result",   out_result, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("rst_less/no_valid", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end

        // Reset wins over a simultaneous request
        rst = 1'b1; in_valid = 1'b1; in_op = 4'h2; in_a = 32'd3; in_b = 32'd4;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_prio/no_valid", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end

        run_op("illegal_1010", 4'hA, 32'h1234_5678, 32'h0000_FFFF, 0);
        run_op("op_1111",      4'hF, 32'h1, 32'hFFFF_FFFF, 1);
        run_op("and",          4'h0, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
        run_op("or",           4'h1, 32'hF000_0000, 32'h0000_000F, 0);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 8);
            if (k < 7) op = legal_ops[k];
            else       op = 4'($urandom_range(0, 15));
            run_op($sformatf("rnd%0d_op%h", n, op), op, rand_operand(), rand_operand(),
                   $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
